// File: rtl/vram_blit_pkg.sv
// rtl/vram_blit_pkg.sv - shared FSM states, width helpers and strobe idle levels for the VRAM blit engine
package vram_blit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_RD,
    ST_WR,
    ST_REC
  } blit_state_e;

  localparam logic STROBE_IDLE = 1'b1;
  localparam logic OE_IDLE     = 1'b0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blit_region_picker.sv
// rtl/blit_region_picker.sv - combinational lowest-set-bit priority encoder over the active region mask
module blit_region_picker #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/vram_blit_engine.sv
// rtl/vram_blit_engine.sv - vblank-gated back->front VRAM region copier with suspend/resume
// Optional BLIT_FILL_EN adds fill_req/fill_value for constant-fill regions.
module vram_blit_engine
  import vram_blit_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int NUM_REGIONS  = 8,
  parameter int REGION_WORDS = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vblank,
  input  logic [NUM_REGIONS-1:0] copy_req,
  output logic [NUM_REGIONS-1:0] pending,
  output logic                   busy,
  output logic                   done,
  output logic                   bus_own,
  output logic [ADDR_W-1:0]      back_vram_addr,
  output logic                   back_vram_rd_low,
  input  logic [DATA_W-1:0]      back_vram_data_in,
  output logic [ADDR_W-1:0]      front_vram_addr,
  output logic [DATA_W-1:0]      front_vram_data_out,
  output logic                   front_vram_data_oe,
  output logic                   front_vram_wr_low
`ifdef BLIT_FILL_EN
  ,
  input  logic [NUM_REGIONS-1:0] fill_req,
  input  logic [DATA_W-1:0]      fill_value
`endif
);

  localparam int REGION_W = idx_w(NUM_REGIONS);
  localparam int OFFSET_W = idx_w(REGION_WORDS);

  logic [NUM_REGIONS-1:0] fill_req_i;
  logic [DATA_W-1:0]      fill_value_i;

`ifdef BLIT_FILL_EN
  assign fill_req_i   = fill_req;
  assign fill_value_i = fill_value;
`else
  assign fill_req_i   = '0;
  assign fill_value_i = '0;
`endif

  blit_state_e            state_q, state_d;
  logic                   vblank_q, vblank_rise;
  logic [NUM_REGIONS-1:0] pending_q, pending_d;
  logic [NUM_REGIONS-1:0] pending_fill_q, pending_fill_d;
  logic [NUM_REGIONS-1:0] active_q, active_d;
  logic [NUM_REGIONS-1:0] active_fill_q, active_fill_d;
  logic [NUM_REGIONS-1:0] cur_mask, clr_mask;
  logic [REGION_W-1:0]    region_q, region_d;
  logic [OFFSET_W-1:0]    offset_q, offset_d;
  logic                   fill_q, fill_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   rd_low_q, rd_low_d;
  logic                   wr_low_q, wr_low_d;
  logic                   oe_q, oe_d;
  logic                   bus_own_q, bus_own_d;
  logic                   done_q, done_d;
  logic [REGION_W-1:0]    pick_idx;
  logic                   pick_valid;

  blit_region_picker #(
    .N     (NUM_REGIONS),
    .IDX_W (REGION_W)
  ) u_picker (
    .mask  (active_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    offset_d    = offset_q;
    fill_d      = fill_q;
    vblank_rise = vblank & ~vblank_q;
    cur_mask    = '0;
    cur_mask[region_q] = 1'b1;
    clr_mask    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (vblank && (|active_q)) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        // A suspended region keeps priority so its saved offset stays meaningful.
        if (offset_q == '0) region_d = pick_idx;
        fill_d  = active_fill_q[region_d];
        state_d = !pick_valid ? ST_IDLE : (fill_d ? ST_WR : ST_RD);
      end
      ST_RD: state_d = ST_WR;
      ST_WR: state_d = ST_REC;
      ST_REC: begin
        if (&offset_q) begin
          clr_mask = cur_mask;
          offset_d = '0;
          state_d  = (vblank && (|(active_q & ~cur_mask))) ? ST_SELECT : ST_IDLE;
        end else begin
          offset_d = offset_q + 1'b1;
          state_d  = !vblank ? ST_IDLE : (fill_q ? ST_WR : ST_RD);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d      = (vblank_rise ? '0 : pending_q) | copy_req;
    pending_fill_d = (vblank_rise ? '0 : pending_fill_q) | fill_req_i;
    active_d       = (active_q & ~clr_mask) | (vblank_rise ? (pending_q | pending_fill_q) : '0);
    active_fill_d  = (active_fill_q & ~clr_mask) | (vblank_rise ? pending_fill_q : '0);

    // Strobes are registered from the next state so they change only on clock edges.
    rd_low_d  = (state_d != ST_RD);
    wr_low_d  = (state_d != ST_WR);
    oe_d      = (state_d == ST_WR) || (state_d == ST_REC);
    bus_own_d = (state_d != ST_IDLE);

    addr_d = addr_q;
    if ((state_d == ST_RD) || ((state_d == ST_WR) && (state_q != ST_RD)))
      addr_d = ADDR_W'({region_d, offset_d});

    data_d = data_q;
    if (state_d == ST_WR)
      data_d = (state_q == ST_RD) ? back_vram_data_in : fill_value_i;

    done_d = (state_d == ST_REC) && (&offset_q) && !(|(active_d & ~cur_mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      vblank_q       <= 1'b0;
      pending_q      <= '0;
      pending_fill_q <= '0;
      active_q       <= '0;
      active_fill_q  <= '0;
      region_q       <= '0;
      offset_q       <= '0;
      fill_q         <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      rd_low_q       <= STROBE_IDLE;
      wr_low_q       <= STROBE_IDLE;
      oe_q           <= OE_IDLE;
      bus_own_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      vblank_q       <= vblank;
      pending_q      <= pending_d;
      pending_fill_q <= pending_fill_d;
      active_q       <= active_d;
      active_fill_q  <= active_fill_d;
      region_q       <= region_d;
      offset_q       <= offset_d;
      fill_q         <= fill_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      rd_low_q       <= rd_low_d;
      wr_low_q       <= wr_low_d;
      oe_q           <= oe_d;
      bus_own_q      <= bus_own_d;
      done_q         <= done_d;
    end
  end

  assign pending             = pending_q | pending_fill_q;
  assign busy                = |active_q;
  assign done                = done_q;
  assign bus_own             = bus_own_q;
  assign back_vram_addr      = addr_q;
  assign back_vram_rd_low    = rd_low_q;
  assign front_vram_addr     = addr_q;
  assign front_vram_data_out = data_q;
  assign front_vram_data_oe  = oe_q;
  assign front_vram_wr_low   = wr_low_q;

endmodule

// File: tb/tb_vram_blit_engine.sv
// tb/tb_vram_blit_engine.sv - self-checking bench for vram_blit_engine against a region/word-order reference model
module tb_vram_blit_engine;

  localparam int AW     = 13;
  localparam int DW     = 8;
  localparam int NR     = 8;
  localparam int RWORDS = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vblank;
  logic [NR-1:0] copy_req;
  logic [NR-1:0] pending;
  logic          busy, done, bus_own;
  logic [AW-1:0] back_vram_addr, front_vram_addr;
  logic          back_vram_rd_low;
  logic [DW-1:0] back_vram_data_in, front_vram_data_out;
  logic          front_vram_data_oe, front_vram_wr_low;
`ifdef BLIT_FILL_EN
  logic [NR-1:0] fill_req;
  logic [DW-1:0] fill_value;
`endif

  logic [DW-1:0] back_mem [0:(1<<AW)-1];
  assign back_vram_data_in = back_mem[back_vram_addr];

  always #5 clk = ~clk;

  vram_blit_engine #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR), .REGION_WORDS(RWORDS)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .vblank              (vblank),
    .copy_req            (copy_req),
    .pending             (pending),
    .busy                (busy),
    .done                (done),
    .bus_own             (bus_own),
    .back_vram_addr      (back_vram_addr),
    .back_vram_rd_low    (back_vram_rd_low),
    .back_vram_data_in   (back_vram_data_in),
    .front_vram_addr     (front_vram_addr),
    .front_vram_data_out (front_vram_data_out),
    .front_vram_data_oe  (front_vram_data_oe),
    .front_vram_wr_low   (front_vram_wr_low)
`ifdef BLIT_FILL_EN
    ,
    .fill_req            (fill_req),
    .fill_value          (fill_value)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_addr[$];
  int mon_data[$];
  int mon_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_cnt = 0;
  int oe_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!front_vram_wr_low) begin
        mon_addr.push_back(int'(front_vram_addr));
        mon_data.push_back(int'(front_vram_data_out));
        mon_cyc.push_back(cyc);
        if (!front_vram_data_oe) oe_bad <= oe_bad + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (!back_vram_rd_low) rd_cnt <= rd_cnt + 1;
    end
  end

  // Expected write stream: requested regions in ascending order, each word 0..RWORDS-1.
  function automatic int score_writes(input int base, input logic [NR-1:0] mask, input int gap,
                                      input int rgap, input int skip_idx, input bit fill, input int fval);
    int exp_q[$];
    int bad = 0;
    int n;
    for (int r = 0; r < NR; r++)
      if (mask[r]) for (int o = 0; o < RWORDS; o++) exp_q.push_back(r * RWORDS + o);
    n = mon_addr.size() - base;
    if (n != exp_q.size()) bad++;
    if (n > exp_q.size()) n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      int exp_d;
      int exp_g;
      exp_d = fill ? fval : int'(back_mem[exp_q[k]]);
      exp_g = ((exp_q[k] % RWORDS) == 0) ? rgap : gap;
      if (mon_addr[base + k] != exp_q[k]) bad++;
      if (mon_data[base + k] != exp_d) bad++;
      if (k > 0 && k != skip_idx && (mon_cyc[base + k] - mon_cyc[base + k - 1]) != exp_g) bad++;
    end
    return bad;
  endfunction

  task automatic pulse_req(input logic [NR-1:0] m);
    @(negedge clk) copy_req = m;
    @(negedge clk) copy_req = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mon_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vblank = 1'b0; copy_req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({back_vram_rd_low, front_vram_wr_low, front_vram_data_oe, bus_own, busy, done} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 110000",
               {back_vram_rd_low, front_vram_wr_low, front_vram_data_oe, bus_own, busy, done});
    end
    checks++;
    if (back_vram_addr !== '0 || front_vram_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h expected 0/0", back_vram_addr, front_vram_addr);
    end
    checks++;
    if (front_vram_data_out !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", front_vram_data_out);
    end
    checks++;
    if (pending !== '0) begin
      errors++;
      $display("FAIL reset_pending: got %h expected 00", pending);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_region();
    int base, dbase, obase, bad;
    bit ok;
    base = mon_addr.size(); dbase = done_cnt; obase = oe_bad;
    pulse_req(8'h01);
    checks++;
    if (pending !== 8'h01) begin
      errors++;
      $display("FAIL single_pending_set: got %h expected 01", pending);
    end
    vblank = 1'b1;
    wait_done(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_timeout: got 0 expected 1"); end
    bad = score_writes(base, 8'h01, 3, 0, -1, 1'b0, 0);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL single_stream: got %0d bad words expected 0", bad); end
    @(negedge clk);
    checks++;
    if (done_cyc !== mon_cyc[mon_cyc.size() - 1] + 1) begin
      errors++;
      $display("FAIL single_done_timing: got cycle %0d expected %0d", done_cyc, mon_cyc[mon_cyc.size() - 1] + 1);
    end
    @(negedge clk);
    checks++;
    if ({pending, busy, bus_own} !== 10'b0) begin
      errors++;
      $display("FAIL single_idle: got pending=%h busy=%b bus_own=%b expected 00/0/0", pending, busy, bus_own);
    end
    checks++;
    if (done_cnt - dbase !== 1 || oe_bad !== obase) begin
      errors++;
      $display("FAIL single_done_oe: got done=%0d oe_bad=%0d expected 1/0", done_cnt - dbase, oe_bad - obase);
    end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_two_regions(input logic [NR-1:0] mask, input string tag);
    int base, dbase, bad;
    bit ok;
    base = mon_addr.size(); dbase = done_cnt;
    pulse_req(mask);
    vblank = 1'b1;
    wait_done(30000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: got 0 expected 1", tag); end
    repeat (2) @(negedge clk);
    bad = score_writes(base, mask, 3, 4, -1, 1'b0, 0);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s_stream mask=%h: got %0d bad words expected 0", tag, mask, bad); end
    checks++;
    if (done_cnt - dbase !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got pulses=%0d busy=%b expected 1/0", tag, done_cnt - dbase, busy);
    end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_suspend_resume();
    int base, bad;
    bit ok;
    base = mon_addr.size();
    pulse_req(8'h04);
    vblank = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!back_vram_rd_low && back_vram_addr == 13'h0864) begin ok = 1'b1; break; end
    end
    vblank = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL suspend_reach_word100: got 0 expected 1"); end
    repeat (6) @(negedge clk);
    checks++;
    if (mon_addr.size() - base !== 101) begin
      errors++;
      $display("FAIL suspend_word_count: got %0d expected 101", mon_addr.size() - base);
    end
    checks++;
    if ({bus_own, front_vram_wr_low, busy} !== 3'b011) begin
      errors++;
      $display("FAIL suspend_bus: got own/wr_low/busy=%b expected 011", {bus_own, front_vram_wr_low, busy});
    end
    vblank = 1'b1;
    wait_done(4000, ok);
    checks++;
    if (!ok || mon_addr.size() - base < 102 || mon_addr[base + 101] !== 32'h0865) begin
      errors++;
      $display("FAIL resume_addr: got %h expected 0865",
               (mon_addr.size() - base >= 102) ? mon_addr[base + 101] : -1);
    end
    bad = score_writes(base, 8'h04, 3, 0, 101, 1'b0, 0);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL resume_stream: got %0d bad words expected 0", bad); end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rerequest();
    int base, bad;
    bit ok;
    pulse_req(8'h08);
    vblank = 1'b1;
    wait_writes(mon_addr.size() + 50, 1000, ok);
    pulse_req(8'h08);
    checks++;
    if (!ok || pending !== 8'h08) begin
      errors++;
      $display("FAIL rereq_pending_mid: got %h expected 08", pending);
    end
    wait_done(4000, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || pending !== 8'h08 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rereq_after_done: got pending=%h busy=%b expected 08/0", pending, busy);
    end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    base = mon_addr.size();
    vblank = 1'b1;
    wait_done(4000, ok);
    repeat (2) @(negedge clk);
    bad = score_writes(base, 8'h08, 3, 0, -1, 1'b0, 0);
    checks++;
    if (!ok || bad !== 0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL rereq_recopy: got %0d bad words pending=%h expected 0/00", bad, pending);
    end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    int base;
    bit ok;
    pulse_req(8'h10);
    vblank = 1'b1;
    wait_writes(mon_addr.size() + 5, 200, ok);
    pulse_req(8'h20);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!front_vram_wr_low) begin ok = 1'b1; break; end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || front_vram_wr_low !== 1'b1 || front_vram_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_strobes: got wr_low=%b oe=%b expected 1/0", front_vram_wr_low, front_vram_data_oe);
    end
    checks++;
    if (pending !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: got pending=%h busy=%b expected 00/0", pending, busy);
    end
    base = mon_addr.size();
    @(negedge clk) rst_n = 1'b1;
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    vblank = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (mon_addr.size() !== base || bus_own !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d writes bus_own=%b expected 0/0", mon_addr.size() - base, bus_own);
    end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask

`ifdef BLIT_FILL_EN
  task automatic test_fill();
    int base, rbase, bad;
    bit ok;
    base = mon_addr.size(); rbase = rd_cnt;
    fill_value = 8'h20;
    @(negedge clk) fill_req = 8'h02;
    @(negedge clk) fill_req = '0;
    vblank = 1'b1;
    wait_done(3000, ok);
    repeat (2) @(negedge clk);
    bad = score_writes(base, 8'h02, 2, 0, -1, 1'b1, 32'h20);
    checks++;
    if (!ok || bad !== 0) begin errors++; $display("FAIL fill_stream: got %0d bad words expected 0", bad); end
    checks++;
    if (rd_cnt !== rbase) begin errors++; $display("FAIL fill_no_read: got %0d reads expected 0", rd_cnt - rbase); end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    logic [NR-1:0] rmask;
    for (int i = 0; i < (1 << AW); i++) back_mem[i] = DW'($urandom);
`ifdef BLIT_FILL_EN
    fill_req = '0;
    fill_value = '0;
`endif
    test_reset();
    test_single_region();
    test_two_regions(8'h81, "two_regions");
    test_suspend_resume();
    test_rerequest();
    test_reset_mid_word();
    rmask = NR'($urandom_range(1, 255));
    test_two_regions(rmask, "random_mask");
`ifdef BLIT_FILL_EN
    test_fill();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
